// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants and occupancy-state helper for the instruction prefetch queue.
package instr_fetch_queue_pkg;

  localparam int          IFQ_INSTR_WIDTH = 32;
  localparam int          IFQ_ADDR_WIDTH  = 32;
  localparam logic [31:0] IFQ_INSTR_NOP   = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic [1:0] {
    IFQ_EMPTY,
    IFQ_PARTIAL,
    IFQ_FULL
  } ifq_state_e;

  // Queue state is a pure function of occupancy; there is no separate state register.
  function automatic ifq_state_e ifq_state(input int unsigned count, input int unsigned depth);
    if (count == 0)          return IFQ_EMPTY;
    else if (count >= depth) return IFQ_FULL;
    else                     return IFQ_PARTIAL;
  endfunction

endpackage

// File: rtl/ifq_storage.sv
// Entry storage for the prefetch queue: one synchronous write port, one
// asynchronous read port so the head entry is visible without a read cycle.
module ifq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk_87,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk_87) begin
      if (we && (waddr == PTR_W'(gi))) begin
        mem_q[gi] <= wdata;
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetch FIFO between fetch and decode: absorbs fetch output while decode is
// stalled and empties on a taken branch/jump flush.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int INSTR_WIDTH = IFQ_INSTR_WIDTH,
  parameter int ADDR_WIDTH  = IFQ_ADDR_WIDTH
) (
  input  logic                     clk_87,
  input  logic                     rst_87,
  input  logic                     if_valid_87,
  input  logic [INSTR_WIDTH-1:0]   if_instr_87,
  input  logic [ADDR_WIDTH-1:0]    if_pc_87,
  output logic                     if_ready_87,
  input  logic                     stall_87,
  input  logic                     flush_87,
  output logic                     id_valid_87,
  output logic [INSTR_WIDTH-1:0]   id_instr_87,
  output logic [ADDR_WIDTH-1:0]    id_pc_87,
  output logic [$clog2(DEPTH):0]   count_87
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + INSTR_WIDTH;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] head_entry;
  ifq_state_e         state;
  logic               push, pop;

  assign state       = ifq_state(32'(count_q), DEPTH);
  // Ready comes only from registered occupancy, so a full queue refuses a push
  // even when decode pops in the same cycle.
  assign if_ready_87 = (state != IFQ_FULL);
  assign id_valid_87 = (state != IFQ_EMPTY);
  assign push        = if_valid_87 & if_ready_87;
  assign pop         = id_valid_87 & ~stall_87;
  assign count_87    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_87) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_87) begin
    if (rst_87) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  ifq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_storage (
    .clk_87 (clk_87),
    .we     (push & ~flush_87),
    .waddr  (wr_ptr_q),
    .wdata  ({if_pc_87, if_instr_87}),
    .raddr  (rd_ptr_q),
    .rdata  (head_entry)
  );

  // An empty queue presents a NOP so decode sees a bubble, not stale storage.
  assign id_instr_87 = id_valid_87 ? head_entry[INSTR_WIDTH-1:0] : INSTR_WIDTH'(IFQ_INSTR_NOP);
  assign id_pc_87    = id_valid_87 ? head_entry[ENTRY_W-1 -: ADDR_WIDTH] : '0;

  a_no_overflow: assert property (@(posedge clk_87) disable iff (rst_87)
    !(push && (count_q == CNT_W'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk_87) disable iff (rst_87)
    !(pop && (count_q == '0)));

endmodule
